tri_edge_scheduler: RTL and testbench

TRI_EDGE_SCHEDULER -- requirements
Module: tri_edge_scheduler

---
 rtl/tri_edge_scheduler_pkg.sv | 18 +
 rtl/tri_fifo.sv | 60 ++++++
 rtl/tri_edge_scheduler.sv | 132 +++++++++++++
 tb/tb_tri_edge_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_edge_scheduler_pkg.sv
// Shared encodings for the triangle edge scheduler: FSM states, edge indices, default sizing.
package tri_edge_scheduler_pkg;

    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } sched_state_t;

    localparam logic [1:0] EDGE0 = 2'd0;
    localparam logic [1:0] EDGE1 = 2'd1;
    localparam logic [1:0] EDGE2 = 2'd2;

endpackage

// File: rtl/tri_fifo.sv
// Triangle storage FIFO. The head entry is readable combinationally, and push/pop take effect on the next edge.
// Pushes are dropped when the FIFO is full and pops are dropped when it is empty; flags come from the count only.
module tri_fifo #(
    parameter int DW    = 60,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by simple overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tri_edge_scheduler.sv
// Buffers triangles and feeds their three edges to a shared line rasterizer. ln_start is 3 cycles after accept into an idle block.
// tri_ready is FIFO-not-full with no bypass. Define TRI_EDGE_CULL_EN to skip zero-length edges without starting the rasterizer.
module tri_edge_scheduler
    import tri_edge_scheduler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tri_valid,
    output logic             tri_ready,
    input  logic [WIDTH-1:0] ix_p1,
    input  logic [WIDTH-1:0] iy_p1,
    input  logic [WIDTH-1:0] ix_p2,
    input  logic [WIDTH-1:0] iy_p2,
    input  logic [WIDTH-1:0] ix_p3,
    input  logic [WIDTH-1:0] iy_p3,
    output logic             ln_start,
    input  logic             ln_busy,
    input  logic             ln_done,
    output logic [WIDTH-1:0] x_out1,
    output logic [WIDTH-1:0] y_out1,
    output logic [WIDTH-1:0] x_out2,
    output logic [WIDTH-1:0] y_out2,
    output logic             tri_done,
    output logic             busy
);

    localparam int TW = 6 * WIDTH;

    sched_state_t    state;
    logic [1:0]      edge_idx;
    logic [1:0]      next_idx;
    logic [TW-1:0]   work;
    logic [TW-1:0]   fifo_rd_dat;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;

    // Endpoints for an edge index; out1 is always the first-named vertex.
    function automatic logic [4*WIDTH-1:0] edge_sel(input logic [1:0] idx, input logic [TW-1:0] t);
        logic [WIDTH-1:0] x1, y1, x2, y2, x3, y3;
        {x1, y1, x2, y2, x3, y3} = t;
        case (idx)
            EDGE1:   edge_sel = {x1, y1, x3, y3};
            EDGE2:   edge_sel = {x2, y2, x3, y3};
            default: edge_sel = {x1, y1, x2, y2};
        endcase
    endfunction

    assign tri_ready = ~fifo_full & ~reset;
    assign fifo_push = tri_valid & tri_ready;
    assign fifo_pop  = (state == IDLE) & ~fifo_empty;
    assign next_idx  = edge_idx + 2'd1;
    assign busy      = ~fifo_empty | (state != IDLE);

    tri_fifo #(
        .DW    (TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat ({ix_p1, iy_p1, ix_p2, iy_p2, ix_p3, iy_p3}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            edge_idx <= EDGE0;
            work     <= '0;
            x_out1   <= '0;
            y_out1   <= '0;
            x_out2   <= '0;
            y_out2   <= '0;
            ln_start <= 1'b0;
            tri_done <= 1'b0;
        end else begin
            ln_start <= 1'b0;
            tri_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        work     <= fifo_rd_dat;
                        edge_idx <= EDGE0;
                        {x_out1, y_out1, x_out2, y_out2} <= edge_sel(EDGE0, fifo_rd_dat);
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef TRI_EDGE_CULL_EN
                    if ((x_out1 == x_out2) && (y_out1 == y_out2)) begin
                        if (edge_idx == EDGE2) begin
                            state <= DONE;
                        end else begin
                            edge_idx <= next_idx;
                            {x_out1, y_out1, x_out2, y_out2} <= edge_sel(next_idx, work);
                        end
                    end else
`endif
                    if (!ln_busy) begin
                        ln_start <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (ln_done) begin
                        if (edge_idx == EDGE2) begin
                            state <= DONE;
                        end else begin
                            edge_idx <= next_idx;
                            {x_out1, y_out1, x_out2, y_out2} <= edge_sel(next_idx, work);
                            state    <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    tri_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_edge_scheduler.sv
// Directed bench for tri_edge_scheduler: latency, backpressure, busy stall, reset abort, degenerate edges, spurious done.
module tb_tri_edge_scheduler;

    logic       clk;
    logic       reset;
    logic       tri_valid;
    logic       tri_ready;
    logic [9:0] ix_p1, iy_p1, ix_p2, iy_p2, ix_p3, iy_p3;
    logic       ln_start;
    logic       ln_busy;
    logic       ln_done;
    logic [9:0] x_out1, y_out1, x_out2, y_out2;
    logic       tri_done;
    logic       busy;

    logic       resp_done;
    logic       spur_done;
    logic       hold_done;
    int         resp_delay;

    int         checks;
    int         failures;
    int         start_cnt;
    int         done_cnt;
    int         overlap_cnt;
    logic [39:0] edges [0:255];

`ifdef TRI_EDGE_CULL_EN
    localparam int DEG_STARTS = 2;
    localparam logic [39:0] DEG_FIRST = {10'd7, 10'd7, 10'd9, 10'd1};
`else
    localparam int DEG_STARTS = 3;
    localparam logic [39:0] DEG_FIRST = {10'd7, 10'd7, 10'd7, 10'd7};
`endif

    assign ln_done = resp_done | spur_done;

    tri_edge_scheduler #(
        .WIDTH (10),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .ix_p1     (ix_p1),
        .iy_p1     (iy_p1),
        .ix_p2     (ix_p2),
        .iy_p2     (iy_p2),
        .ix_p3     (ix_p3),
        .iy_p3     (iy_p3),
        .ln_start  (ln_start),
        .ln_busy   (ln_busy),
        .ln_done   (ln_done),
        .x_out1    (x_out1),
        .y_out1    (y_out1),
        .x_out2    (x_out2),
        .y_out2    (y_out2),
        .tri_done  (tri_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got=running required=finished");
        $fatal(1);
    end

    // Monitor: record every started edge and count pulses.
    initial begin
        start_cnt   = 0;
        done_cnt    = 0;
        overlap_cnt = 0;
        forever begin
            @(negedge clk);
            if (ln_start) begin
                edges[start_cnt[7:0]] = {x_out1, y_out1, x_out2, y_out2};
                start_cnt = start_cnt + 1;
            end
            if (tri_done) done_cnt = done_cnt + 1;
            if (tri_done && ln_start) overlap_cnt = overlap_cnt + 1;
        end
    end

    // Rasterizer model: pulses done resp_delay cycles after each start unless held.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ln_start) begin
                wait (!hold_done);
                repeat (resp_delay - 1) @(negedge clk);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h required=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [59:0] mk(input int a, input int b, input int c, input int d,
                                       input int e, input int f);
        return {10'(a), 10'(b), 10'(c), 10'(d), 10'(e), 10'(f)};
    endfunction

    function automatic logic [39:0] mke(input int a, input int b, input int c, input int d);
        return {10'(a), 10'(b), 10'(c), 10'(d)};
    endfunction

    task automatic offer(input logic [59:0] t, input int max_wait, output int waited);
        {ix_p1, iy_p1, ix_p2, iy_p2, ix_p3, iy_p3} = t;
        tri_valid = 1'b1;
        waited = 0;
        while (!tri_ready && waited < max_wait) begin
            @(negedge clk);
            waited = waited + 1;
        end
        check("offer_ready", 64'(tri_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_starts(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (start_cnt < target && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, 64'(start_cnt >= target), 64'd1);
    endtask

    task automatic wait_dones(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check("idle_reached", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int bs, bd, w, wa, wb, wc, n;
        logic stable_ok;
        logic [59:0] ta, tb, tc, tw;

        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        tri_valid  = 1'b0;
        ln_busy    = 1'b0;
        spur_done  = 1'b0;
        hold_done  = 1'b0;
        resp_delay = 4;
        {ix_p1, iy_p1, ix_p2, iy_p2, ix_p3, iy_p3} = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(tri_ready), 64'd0);
        check("rst_start", 64'(ln_start), 64'd0);
        check("rst_done", 64'(tri_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outs", 64'({x_out1, y_out1, x_out2, y_out2}), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(tri_ready), 64'd1);
        @(negedge clk);

        // Single triangle, start latency and edge order
        bs = start_cnt; bd = done_cnt;
        {ix_p1, iy_p1, ix_p2, iy_p2, ix_p3, iy_p3} = mk(1, 2, 3, 4, 5, 6);
        tri_valid = 1'b1;
        @(negedge clk);
        tri_valid = 1'b0;
        check("lat_c1_start", 64'(ln_start), 64'd0);
        check("lat_c1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("lat_c2_start", 64'(ln_start), 64'd0);
        check("lat_c2_outs", 64'({x_out1, y_out1, x_out2, y_out2}), 64'(mke(1, 2, 3, 4)));
        @(negedge clk);
        check("lat_c3_start", 64'(ln_start), 64'd1);
        wait_dones("single_done_seen", bd + 1, 200);
        repeat (3) @(negedge clk);
        check("single_starts", 64'(start_cnt - bs), 64'd3);
        check("single_dones", 64'(done_cnt - bd), 64'd1);
        check("single_e0", 64'(edges[8'(bs)]), 64'(mke(1, 2, 3, 4)));
        check("single_e1", 64'(edges[8'(bs + 1)]), 64'(mke(1, 2, 5, 6)));
        check("single_e2", 64'(edges[8'(bs + 2)]), 64'(mke(3, 4, 5, 6)));
        wait_idle(50);

        // Spurious done while idle
        bs = start_cnt;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_spur_busy", 64'(busy), 64'd0);
        check("idle_spur_starts", 64'(start_cnt - bs), 64'd0);
        check("idle_spur_ready", 64'(tri_ready), 64'd1);

        // Backpressure with the scheduler stuck in WAIT
        bs = start_cnt; bd = done_cnt;
        tw = mk(100, 101, 102, 103, 104, 105);
        ta = mk(11, 12, 13, 14, 15, 16);
        tb = mk(21, 22, 23, 24, 25, 26);
        tc = mk(31, 32, 33, 34, 35, 36);
        hold_done = 1'b1;
        offer(tw, 20, w);
        tri_valid = 1'b0;
        wait_starts("bp_w_started", bs + 1, 20);
        offer(ta, 20, wa);
        offer(tb, 20, wb);
        check("bp_a_nowait", 64'(wa), 64'd0);
        check("bp_b_nowait", 64'(wb), 64'd0);
        check("bp_full_ready", 64'(tri_ready), 64'd0);
        fork
            offer(tc, 400, wc);
            begin
                repeat (3) @(negedge clk);
                hold_done = 1'b0;
            end
        join
        tri_valid = 1'b0;
        check("bp_c_stalled", 64'(wc != 0), 64'd1);
        check("bp_c_after_pop", 64'(done_cnt - bd), 64'd1);
        wait_dones("bp_all_done", bd + 4, 800);
        repeat (3) @(negedge clk);
        check("bp_starts", 64'(start_cnt - bs), 64'd12);
        check("bp_a_e0", 64'(edges[8'(bs + 3)]), 64'(mke(11, 12, 13, 14)));
        check("bp_b_e0", 64'(edges[8'(bs + 6)]), 64'(mke(21, 22, 23, 24)));
        check("bp_c_e0", 64'(edges[8'(bs + 9)]), 64'(mke(31, 32, 33, 34)));
        check("bp_c_e2", 64'(edges[8'(bs + 11)]), 64'(mke(33, 34, 35, 36)));
        wait_idle(50);

        // ln_busy stall in ISSUE with a spurious done mid-stall
        bs = start_cnt; bd = done_cnt;
        ln_busy = 1'b1;
        offer(mk(40, 41, 42, 43, 44, 45), 20, w);
        tri_valid = 1'b0;
        n = 0;
        while ({x_out1, y_out1, x_out2, y_out2} != mke(40, 41, 42, 43) && n < 10) begin
            @(negedge clk);
            n = n + 1;
        end
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            spur_done = (i == 4);
            @(negedge clk);
            if (ln_start || {x_out1, y_out1, x_out2, y_out2} != mke(40, 41, 42, 43))
                stable_ok = 1'b0;
        end
        spur_done = 1'b0;
        check("busy_stall_stable", 64'(stable_ok), 64'd1);
        check("busy_stall_nostart", 64'(start_cnt - bs), 64'd0);
        ln_busy = 1'b0;
        wait_starts("busy_release_start", bs + 1, 4);
        wait_dones("busy_done_seen", bd + 1, 200);
        repeat (3) @(negedge clk);
        check("busy_starts", 64'(start_cnt - bs), 64'd3);
        check("busy_e0", 64'(edges[8'(bs)]), 64'(mke(40, 41, 42, 43)));
        check("busy_e1", 64'(edges[8'(bs + 1)]), 64'(mke(40, 41, 44, 45)));
        check("busy_e2", 64'(edges[8'(bs + 2)]), 64'(mke(42, 43, 44, 45)));
        wait_idle(50);

        // Reset in WAIT of edge1
        bs = start_cnt; bd = done_cnt;
        offer(mk(50, 51, 52, 53, 54, 55), 20, w);
        tri_valid = 1'b0;
        wait_starts("rstmid_edge1", bs + 2, 100);
        reset = 1'b1;
        #1;
        check("rstmid_start", 64'(ln_start), 64'd0);
        check("rstmid_done", 64'(tri_done), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_outs", 64'({x_out1, y_out1, x_out2, y_out2}), 64'd0);
        @(negedge clk);
        check("rstmid_busy_next", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rstmid_no_done", 64'(done_cnt - bd), 64'd0);
        check("rstmid_starts", 64'(start_cnt - bs), 64'd2);
        check("rstmid_idle", 64'(busy), 64'd0);

        // Degenerate edge0
        bs = start_cnt; bd = done_cnt;
        offer(mk(7, 7, 7, 7, 9, 1), 20, w);
        tri_valid = 1'b0;
        wait_dones("deg_done_seen", bd + 1, 200);
        repeat (3) @(negedge clk);
        check("deg_starts", 64'(start_cnt - bs), 64'(DEG_STARTS));
        check("deg_first", 64'(edges[8'(bs)]), 64'(DEG_FIRST));
        check("deg_last", 64'(edges[8'(bs + DEG_STARTS - 1)]), 64'(mke(7, 7, 9, 1)));
        check("deg_dones", 64'(done_cnt - bd), 64'd1);
        wait_idle(50);

        check("no_start_done_overlap", 64'(overlap_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
